// File: rtl/arith_pkg.sv
// Shared arithmetic-unit definitions: controller state encoding used by
// the sequential multiplier and divider, plus their handshake timing rules.
package arith_pkg;

  // Handshake: start is sampled only while busy=0. busy rises on the
  // accepting edge. done is a one-cycle pulse and results hold until the
  // next done. A start seen in the done cycle is accepted, because the
  // controller is already back in IDLE.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIVIDE = 2'd1,
    FIXUP  = 2'd2
  } state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift {r,q} left, trial-subtract d,
// keep or restore, and shift in the new quotient bit.
// Ports: r/q/d = current partial remainder, quotient, divisor magnitudes;
//        r_next/q_next = values after this iteration.
module div_step
  import arith_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [N:0]   r,
  input  logic [N-1:0] q,
  input  logic [N:0]   d,
  output logic [N:0]   r_next,
  output logic [N-1:0] q_next
);

  logic [N+1:0] rs;
  logic [N+1:0] t;

  always_comb begin
    rs = {r, q[N-1]};
    t  = rs - {1'b0, d};
    // t[N+1] set means the trial subtraction went negative: restore.
    if (!t[N+1]) begin
      r_next = t[N:0];
      q_next = {q[N-2:0], 1'b1};
    end else begin
      r_next = rs[N:0];
      q_next = {q[N-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/seq_divider.sv
// Sequential signed restoring divider with a start/busy/done handshake.
// Ports: start/dividend/divisor in; busy, done pulse, quotient, remainder,
//        div_zero and overflow out (results and flags held until next done).
module seq_divider
  import arith_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div_zero,
  output logic         overflow
);

  localparam int CW = $clog2(N) + 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);
  localparam logic [N-1:0] MINV = {1'b1, {(N-1){1'b0}}};

  state_t state, state_n;
  logic accept;

  logic [CW-1:0] count;
  logic [N-1:0]  q_reg;
  logic [N:0]    d_reg;
  logic [N:0]    r_reg;
  logic          sign_dd, sign_dv;
  logic          dz, ovf;

  logic [N:0]    r_next;
  logic [N-1:0]  q_next;
  logic [N:0]    r_neg;

  function automatic logic [N-1:0] mag(input logic [N-1:0] v);
    return v[N-1] ? -v : v;
  endfunction

  div_step #(.N(N)) u_step (
    .r      (r_reg),
    .q      (q_reg),
    .d      (d_reg),
    .r_next (r_next),
    .q_next (q_next)
  );

  assign busy  = (state != IDLE);
  assign r_neg = -r_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_n;
  end

  // Divide-by-zero spends one idle cycle in DIVIDE without iterating,
  // giving the three-clock latency for that case.
  always_comb begin
    state_n = state;
    accept  = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_n = DIVIDE;
        end
      end
      DIVIDE: begin
        if (dz || count == LAST) state_n = FIXUP;
      end
      FIXUP:   state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count     <= '0;
      q_reg     <= '0;
      d_reg     <= '0;
      r_reg     <= '0;
      sign_dd   <= 1'b0;
      sign_dv   <= 1'b0;
      dz        <= 1'b0;
      ovf       <= 1'b0;
      done      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        q_reg   <= mag(dividend);
        d_reg   <= {1'b0, mag(divisor)};
        r_reg   <= '0;
        sign_dd <= dividend[N-1];
        sign_dv <= divisor[N-1];
        dz      <= (divisor == '0);
        ovf     <= (dividend == MINV) && (divisor == '1);
        count   <= '0;
      end else if (state == DIVIDE && !dz) begin
        r_reg <= r_next;
        q_reg <= q_next;
        count <= count + CW'(1);
      end else if (state == FIXUP) begin
        done     <= 1'b1;
        div_zero <= dz;
        overflow <= ovf;
        if (dz) begin
          // q_reg still holds |dividend|; re-sign it.
          quotient  <= '1;
          remainder <= sign_dd ? -q_reg : q_reg;
        end else begin
          quotient  <= (sign_dd ^ sign_dv) ? -q_reg : q_reg;
          remainder <= sign_dd ? r_neg[N-1:0] : r_reg[N-1:0];
        end
      end
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Directed self-checking bench for seq_divider (N=8).
// Table-driven ops plus reset, busy-start and mid-operation reset sequences.
module tb_seq_divider;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [7:0] dividend = '0;
  logic [7:0] divisor = '0;
  logic       busy, done, div_zero, overflow;
  logic [7:0] quotient, remainder;

  int checks = 0;
  int failures = 0;

  seq_divider #(.N(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] dd;
    logic [7:0] dv;
    logic [7:0] q;
    logic [7:0] r;
    logic       dz;
    logic       ov;
    int         lat;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Called at a negedge; launches one op and waits for done.
  task automatic run_op(input logic [7:0] dd, input logic [7:0] dv,
                        input logic [7:0] q, input logic [7:0] r,
                        input logic dz, input logic ov, input int lat,
                        input bit inject, input string tag);
    int k;
    bit got;
    start = 1'b1;
    dividend = dd;
    divisor = dv;
    @(posedge clk);
    #1;
    start = 1'b0;
    dividend = ~dd;
    divisor = dd ^ 8'h5A;
    k = 1;
    got = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (k == 1) begin
        chk($sformatf("%s busy", tag), 32'(busy), 32'd1);
      end
      if (done) begin
        got = 1'b1;
        break;
      end
      if (inject && k == 4) begin
        start = 1'b1;
        dividend = 8'd50;
        divisor = 8'd5;
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      k++;
    end
    chk($sformatf("%s done_seen", tag), 32'(got), 32'd1);
    chk($sformatf("%s latency", tag), k, lat);
    chk($sformatf("%s quotient", tag), 32'(quotient), 32'(q));
    chk($sformatf("%s remainder", tag), 32'(remainder), 32'(r));
    chk($sformatf("%s div_zero", tag), 32'(div_zero), 32'(dz));
    chk($sformatf("%s overflow", tag), 32'(overflow), 32'(ov));
  endtask

  initial begin
    vecs[0]  = '{8'd100, 8'd7,   8'h0E, 8'h02, 1'b0, 1'b0, 10};
    vecs[1]  = '{8'h9C,  8'd7,   8'hF2, 8'hFE, 1'b0, 1'b0, 10};
    vecs[2]  = '{8'd100, 8'hF9,  8'hF2, 8'h02, 1'b0, 1'b0, 10};
    vecs[3]  = '{8'h80,  8'hFF,  8'h80, 8'h00, 1'b0, 1'b1, 10};
    vecs[4]  = '{8'h80,  8'h01,  8'h80, 8'h00, 1'b0, 1'b0, 10};
    vecs[5]  = '{8'd55,  8'd0,   8'hFF, 8'h37, 1'b1, 1'b0, 3};
    vecs[6]  = '{8'hC9,  8'd0,   8'hFF, 8'hC9, 1'b1, 1'b0, 3};
    vecs[7]  = '{8'd7,   8'd100, 8'h00, 8'h07, 1'b0, 1'b0, 10};
    vecs[8]  = '{8'hFF,  8'h01,  8'hFF, 8'h00, 1'b0, 1'b0, 10};
    vecs[9]  = '{8'h7F,  8'h80,  8'h00, 8'h7F, 1'b0, 1'b0, 10};
    vecs[10] = '{8'h80,  8'h80,  8'h01, 8'h00, 1'b0, 1'b0, 10};
    vecs[11] = '{8'h80,  8'd7,   8'hEE, 8'hFE, 1'b0, 1'b0, 10};
    vecs[12] = '{8'd0,   8'd5,   8'h00, 8'h00, 1'b0, 1'b0, 10};

    repeat (2) @(negedge clk);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset quotient", 32'(quotient), 32'd0);
    chk("reset remainder", 32'(remainder), 32'd0);
    chk("reset div_zero", 32'(div_zero), 32'd0);
    chk("reset overflow", 32'(overflow), 32'd0);
    reset = 1'b1;
    @(negedge clk);

    // Ops chain back-to-back: each start lands in the previous done cycle.
    foreach (vecs[i]) begin
      run_op(vecs[i].dd, vecs[i].dv, vecs[i].q, vecs[i].r,
             vecs[i].dz, vecs[i].ov, vecs[i].lat, 1'b0,
             $sformatf("vec%0d", i));
    end

    run_op(8'd100, 8'd7, 8'h0E, 8'h02, 1'b0, 1'b0, 10, 1'b1, "busy_start");

    // Reset in the middle of an operation.
    start = 1'b1;
    dividend = 8'd100;
    divisor = 8'd7;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("midrst busy", 32'(busy), 32'd0);
    chk("midrst done", 32'(done), 32'd0);
    chk("midrst quotient", 32'(quotient), 32'd0);
    chk("midrst remainder", 32'(remainder), 32'd0);
    chk("midrst flags", 32'({div_zero, overflow}), 32'd0);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (i == 2) reset = 1'b1;
      chk($sformatf("midrst no_done%0d", i), 32'(done), 32'd0);
    end
    run_op(8'd9, 8'd3, 8'h03, 8'h00, 1'b0, 1'b0, 10, 1'b0, "after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
